// File: rtl/downcount_tick_gen_if.sv
// Control/status bundle for downcount_tick_gen.
// The master drives the requests and the slave returns the counter status.
interface downcount_tick_gen_if #(
    parameter int N = 8
);
    logic         start;
    logic         stop;
    logic         enable;
    logic         oneshot;
    logic [N-1:0] period;
    logic [N-1:0] count;
    logic         tick;
    logic [N-1:0] tick_count;
    logic         busy;
    logic         done;
    logic         err;

    modport master (
        output start, stop, enable, oneshot, period,
        input  count, tick, tick_count, busy, done, err
    );

    modport slave (
        input  start, stop, enable, oneshot, period,
        output count, tick, tick_count, busy, done, err
    );
endinterface

// File: rtl/downcount_tick_gen.sv
// Loadable, auto-reloading down-counter that emits a one-cycle tick every
// `period` enabled clocks, in periodic or one-shot mode.
module downcount_tick_gen #(
    parameter int n = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    downcount_tick_gen_if.slave   dtg
);
    typedef enum logic {IDLE, RUN} state_t;

    localparam logic [n-1:0] ONE = n'(1);

    state_t       state_q, state_d;
    logic [n-1:0] count_q, count_d;
    logic [n-1:0] tcnt_q, tcnt_d;
    logic [n-1:0] per_q, per_d;
    logic         mode_q, mode_d;
    logic         tick_q, tick_d;
    logic         done_q, done_d;
    logic         err_q, err_d;

    logic start_ok;
    logic expire;

    assign start_ok = dtg.start && (dtg.period != '0);
    assign expire   = (state_q == RUN) && dtg.enable && (count_q == '0);

    // State and all registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            count_q <= '0;
            tcnt_q  <= '0;
            per_q   <= '0;
            mode_q  <= 1'b0;
            tick_q  <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            tcnt_q  <= tcnt_d;
            per_q   <= per_d;
            mode_q  <= mode_d;
            tick_q  <= tick_d;
            done_q  <= done_d;
            err_q   <= err_d;
        end
    end

    // A rejected start still owns the edge, so it also blocks expiry.
    always_comb begin
        state_d = state_q;
        if (dtg.stop)
            state_d = IDLE;
        else if (start_ok)
            state_d = RUN;
        else if (!dtg.start && expire && mode_q)
            state_d = IDLE;
    end

    always_comb begin
        count_d = count_q;
        tcnt_d  = tcnt_q;
        per_d   = per_q;
        mode_d  = mode_q;
        tick_d  = 1'b0;
        done_d  = done_q;
        err_d   = 1'b0;
        if (dtg.stop) begin
            count_d = '0;
        end else if (dtg.start) begin
            if (dtg.period == '0) begin
                err_d = 1'b1;
            end else begin
                per_d   = dtg.period;
                mode_d  = dtg.oneshot;
                count_d = dtg.period - ONE;
                tcnt_d  = '0;
                done_d  = 1'b0;
            end
        end else if (state_q == RUN && dtg.enable) begin
            if (count_q != '0) begin
                count_d = count_q - ONE;
            end else begin
                tick_d = 1'b1;
                tcnt_d = tcnt_q + ONE;
                if (mode_q) begin
                    count_d = '0;
                    done_d  = 1'b1;
                end else begin
                    count_d = per_q - ONE;
                end
            end
        end
    end

    assign dtg.count      = count_q;
    assign dtg.tick       = tick_q;
    assign dtg.tick_count = tcnt_q;
    assign dtg.busy       = (state_q == RUN);
    assign dtg.done       = done_q;
    assign dtg.err        = err_q;
endmodule

// File: tb/tb_downcount_tick_gen.sv
// Directed bench for downcount_tick_gen: periodic, one-shot, enable stretch,
// error/stop priority, period-1 wrap and asynchronous reset mid-run.
module tb_downcount_tick_gen;
    logic clk = 1'b0;
    logic rst = 1'b0;
    int   n_checks = 0;
    int   n_fails  = 0;

    downcount_tick_gen_if #(.N(8)) dtg ();

    downcount_tick_gen #(.n(8)) dut (
        .clk (clk),
        .rst (rst),
        .dtg (dtg)
    );

    always #5 clk = ~clk;

    // Advance one rising edge; sample and drive 1 time unit after it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        dtg.start   = 1'b0;
        dtg.stop    = 1'b0;
        dtg.enable  = 1'b1;
        dtg.oneshot = 1'b0;
        dtg.period  = 8'd0;
    endtask

    task automatic do_start(input logic [7:0] p, input logic os);
        dtg.period  = p;
        dtg.oneshot = os;
        dtg.start   = 1'b1;
        step();
        dtg.start   = 1'b0;
    endtask

    task automatic do_stop();
        dtg.stop = 1'b1;
        step();
        dtg.stop = 1'b0;
    endtask

    task automatic test_reset();
        idle_inputs();
        #1 rst = 1'b1;
        step();
        step();
        n_checks++;
        if ({dtg.count, dtg.tick_count} !== 16'h0000) begin
            n_fails++;
            $display("FAIL reset_counts: got count=%0d tick_count=%0d, want 0 0", dtg.count, dtg.tick_count);
        end
        n_checks++;
        if ({dtg.tick, dtg.busy, dtg.done, dtg.err} !== 4'b0000) begin
            n_fails++;
            $display("FAIL reset_flags: got tick/busy/done/err=%b, want 0000", {dtg.tick, dtg.busy, dtg.done, dtg.err});
        end
        rst = 1'b0;
        step();
    endtask

    task automatic test_periodic();
        logic [7:0] exp_cnt [12] = '{2, 1, 0, 3, 2, 1, 0, 3, 2, 1, 0, 3};
        do_start(8'd4, 1'b0);
        n_checks++;
        if (dtg.count !== 8'd3 || dtg.busy !== 1'b1 || dtg.tick !== 1'b0) begin
            n_fails++;
            $display("FAIL periodic_start: got count=%0d busy=%b tick=%b, want 3 1 0", dtg.count, dtg.busy, dtg.tick);
        end
        for (int k = 1; k <= 12; k++) begin
            step();
            n_checks++;
            if (dtg.tick !== (k % 4 == 0) || dtg.count !== exp_cnt[k-1] || dtg.tick_count !== 8'(k / 4)) begin
                n_fails++;
                $display("FAIL periodic_clk%0d: got tick=%b count=%0d tc=%0d, want %b %0d %0d",
                         k, dtg.tick, dtg.count, dtg.tick_count, (k % 4 == 0), exp_cnt[k-1], k / 4);
            end
        end
        do_stop();
        n_checks++;
        if (dtg.busy !== 1'b0 || dtg.count !== 8'd0 || dtg.tick !== 1'b0) begin
            n_fails++;
            $display("FAIL periodic_stop: got busy=%b count=%0d tick=%b, want 0 0 0", dtg.busy, dtg.count, dtg.tick);
        end
    endtask

    task automatic test_oneshot();
        do_start(8'd3, 1'b1);
        for (int k = 1; k <= 6; k++) begin
            step();
            n_checks++;
            if (dtg.tick !== (k == 3) || dtg.busy !== (k < 3) || dtg.done !== (k >= 3)) begin
                n_fails++;
                $display("FAIL oneshot_clk%0d: got tick=%b busy=%b done=%b, want %b %b %b",
                         k, dtg.tick, dtg.busy, dtg.done, (k == 3), (k < 3), (k >= 3));
            end
        end
        n_checks++;
        if (dtg.tick_count !== 8'd1 || dtg.count !== 8'd0) begin
            n_fails++;
            $display("FAIL oneshot_final: got tc=%0d count=%0d, want 1 0", dtg.tick_count, dtg.count);
        end
        do_start(8'd3, 1'b0);
        n_checks++;
        if (dtg.done !== 1'b0 || dtg.busy !== 1'b1 || dtg.tick_count !== 8'd0) begin
            n_fails++;
            $display("FAIL oneshot_restart: got done=%b busy=%b tc=%0d, want 0 1 0", dtg.done, dtg.busy, dtg.tick_count);
        end
        do_stop();
    endtask

    task automatic test_enable_stretch();
        // Expected per clock after start: two enabled, two frozen, three enabled.
        logic [7:0] exp_cnt [7] = '{3, 2, 2, 2, 1, 0, 4};
        logic       en_seq  [7] = '{1, 1, 0, 0, 1, 1, 1};
        do_start(8'd5, 1'b0);
        for (int k = 1; k <= 7; k++) begin
            dtg.enable = en_seq[k-1];
            step();
            n_checks++;
            if (dtg.count !== exp_cnt[k-1] || dtg.tick !== (k == 7)) begin
                n_fails++;
                $display("FAIL stretch_clk%0d: got count=%0d tick=%b, want %0d %b",
                         k, dtg.count, dtg.tick, exp_cnt[k-1], (k == 7));
            end
        end
        dtg.enable = 1'b1;
        do_stop();
    endtask

    task automatic test_err_and_priority();
        do_start(8'd0, 1'b0);
        n_checks++;
        if (dtg.err !== 1'b1 || dtg.busy !== 1'b0 || dtg.count !== 8'd0) begin
            n_fails++;
            $display("FAIL err_idle: got err=%b busy=%b count=%0d, want 1 0 0", dtg.err, dtg.busy, dtg.count);
        end
        step();
        n_checks++;
        if (dtg.err !== 1'b0) begin
            n_fails++;
            $display("FAIL err_pulse: got err=%b, want 0", dtg.err);
        end
        do_start(8'd4, 1'b0);
        do_start(8'd0, 1'b0);
        n_checks++;
        if (dtg.err !== 1'b1 || dtg.busy !== 1'b1 || dtg.count !== 8'd3) begin
            n_fails++;
            $display("FAIL err_run: got err=%b busy=%b count=%0d, want 1 1 3", dtg.err, dtg.busy, dtg.count);
        end
        step();
        step();
        step();
        // count is 0 now; start+stop together must still win over expiry.
        dtg.period = 8'd6;
        dtg.start  = 1'b1;
        dtg.stop   = 1'b1;
        step();
        dtg.start  = 1'b0;
        dtg.stop   = 1'b0;
        n_checks++;
        if (dtg.busy !== 1'b0 || dtg.count !== 8'd0 || dtg.tick !== 1'b0) begin
            n_fails++;
            $display("FAIL start_stop: got busy=%b count=%0d tick=%b, want 0 0 0", dtg.busy, dtg.count, dtg.tick);
        end
    endtask

    task automatic test_period1_wrap();
        logic [7:0] exp_tc;
        do_start(8'd1, 1'b0);
        for (int k = 1; k <= 260; k++) begin
            step();
            exp_tc = 8'(k % 256);
            n_checks++;
            if (dtg.tick !== 1'b1 || dtg.tick_count !== exp_tc) begin
                n_fails++;
                $display("FAIL p1_clk%0d: got tick=%b tc=%0d, want 1 %0d", k, dtg.tick, dtg.tick_count, exp_tc);
            end
        end
        do_start(8'd2, 1'b0);
        n_checks++;
        if (dtg.tick !== 1'b0 || dtg.tick_count !== 8'd0 || dtg.count !== 8'd1) begin
            n_fails++;
            $display("FAIL restart_p2: got tick=%b tc=%0d count=%0d, want 0 0 1", dtg.tick, dtg.tick_count, dtg.count);
        end
        step();
        n_checks++;
        if (dtg.tick !== 1'b0 || dtg.count !== 8'd0) begin
            n_fails++;
            $display("FAIL restart_p2_clk1: got tick=%b count=%0d, want 0 0", dtg.tick, dtg.count);
        end
        step();
        n_checks++;
        if (dtg.tick !== 1'b1 || dtg.tick_count !== 8'd1 || dtg.count !== 8'd1) begin
            n_fails++;
            $display("FAIL restart_p2_clk2: got tick=%b tc=%0d count=%0d, want 1 1 1", dtg.tick, dtg.tick_count, dtg.count);
        end
        do_stop();
    endtask

    task automatic test_reset_midrun();
        do_start(8'd8, 1'b0);
        step();
        step();
        n_checks++;
        if (dtg.count !== 8'd5) begin
            n_fails++;
            $display("FAIL midrun_pre: got count=%0d, want 5", dtg.count);
        end
        rst = 1'b1;
        #1;
        n_checks++;
        if ({dtg.count, dtg.tick_count, dtg.tick, dtg.busy, dtg.done, dtg.err} !== 20'h0) begin
            n_fails++;
            $display("FAIL midrun_async: got count=%0d tc=%0d tick/busy/done/err=%b, want all 0",
                     dtg.count, dtg.tick_count, {dtg.tick, dtg.busy, dtg.done, dtg.err});
        end
        step();
        rst = 1'b0;
        for (int k = 1; k <= 10; k++) begin
            step();
            n_checks++;
            if (dtg.tick !== 1'b0 || dtg.busy !== 1'b0 || dtg.count !== 8'd0) begin
                n_fails++;
                $display("FAIL midrun_after%0d: got tick=%b busy=%b count=%0d, want 0 0 0", k, dtg.tick, dtg.busy, dtg.count);
            end
        end
    endtask

    initial begin
        test_reset();
        test_periodic();
        test_oneshot();
        test_enable_stretch();
        test_err_and_priority();
        test_period1_wrap();
        test_reset_midrun();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end
endmodule
